// File: rtl/pueo_evhdr_pkg.sv
// rtl/pueo_evhdr_pkg.sv - shared types and constants for the event-header framer
package pueo_evhdr_pkg;
  localparam logic [15:0] EVHDR_MAGIC  = 16'hE5E1;
  localparam int          DROPFLAG_BIT = 32;

  typedef enum logic [1:0] {IDLE, B0, B1, B2} evhdr_state_t;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] evnum;
    logic [47:0] ts;
    logic        dropflag;
  } evhdr_entry_t;
endpackage

// File: rtl/evhdr_sync_fifo.sv
// rtl/evhdr_sync_fifo.sv - single-clock FIFO of event entries with a registered head
module evhdr_sync_fifo
  import pueo_evhdr_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr,
  input  evhdr_entry_t             i_wdata,
  input  logic                     i_pop,
  output evhdr_entry_t             o_head,
  output logic                     o_head_valid,
  output logic                     o_next_avail,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  evhdr_entry_t  r_mem [DEPTH];
  evhdr_entry_t  r_head;
  logic          r_head_valid;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_wr;
  logic          w_pop;
  logic [AW-1:0] w_rd_next;

  assign o_full       = (r_count == (AW+1)'(DEPTH));
  assign o_empty      = (r_count == '0);
  assign o_next_avail = (r_count > (AW+1)'(1));
  assign o_count      = r_count;
  assign o_head       = r_head;
  assign o_head_valid = r_head_valid;
  assign w_wr         = i_wr & ~o_full;
  assign w_pop        = i_pop & r_head_valid;
  assign w_rd_next    = r_rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

  // The head register is reloaded from the entry behind it on a pop, so a
  // following frame can start without a bubble when one is already stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_head       <= '0;
      r_head_valid <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= w_rd_next;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_head_valid <= o_next_avail;
        r_head       <= r_mem[w_rd_next];
      end else if (!r_head_valid && !o_empty) begin
        r_head_valid <= 1'b1;
        r_head       <= r_mem[r_rd_ptr];
      end
    end
  end
endmodule

// File: rtl/pueo_evhdr_framer.sv
// rtl/pueo_evhdr_framer.sv - turns trigger records into 3-beat event-header frames
module pueo_evhdr_framer
  import pueo_evhdr_pkg::*;
#(
  parameter int          DEPTH = 16,
  parameter logic [15:0] MAGIC = EVHDR_MAGIC
) (
  input  logic                   sysclk_i,
  input  logic                   sysrst_n_i,
  input  logic                   runrst_i,
  input  logic [63:0]            s_hdr_tdata,
  input  logic                   s_hdr_tvalid,
  output logic                   s_hdr_tready,
  output logic [63:0]            m_ev_tdata,
  output logic                   m_ev_tvalid,
  input  logic                   m_ev_tready,
  output logic                   m_ev_tlast,
  output logic [15:0]            drop_count_o,
  output logic                   overflow_o,
  output logic [$clog2(DEPTH):0] fifo_count_o
);
  evhdr_state_t r_state, w_state_next;
  logic         r_tready;
  logic [47:0]  r_ts;
  logic [31:0]  r_evnum;
  logic [15:0]  r_drop_count;
  logic         r_overflow;
  logic         r_pend_drop;

  logic         w_accept, w_write, w_drop, w_pop;
  logic         w_full, w_empty, w_head_valid, w_next_avail;
  logic [47:0]  w_ts;
  logic [31:0]  w_evnum;
  logic [15:0]  w_drop_base;
  logic         w_ovf_base;
  logic [63:0]  w_beat0;
  evhdr_entry_t w_entry, w_head;

  assign w_accept    = s_hdr_tvalid & r_tready;
  assign w_write     = w_accept & ~w_full;
  assign w_drop      = w_accept & w_full;
  // runrst zeroes the values seen by a record accepted in the same cycle
  assign w_ts        = runrst_i ? '0 : r_ts;
  assign w_evnum     = runrst_i ? '0 : r_evnum;
  assign w_drop_base = runrst_i ? '0 : r_drop_count;
  assign w_ovf_base  = runrst_i ? 1'b0 : r_overflow;
  assign w_entry     = '{data: s_hdr_tdata, evnum: w_evnum, ts: w_ts, dropflag: r_pend_drop};

  assign s_hdr_tready = r_tready;
  assign drop_count_o = r_drop_count;
  assign overflow_o   = r_overflow;

  evhdr_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (sysclk_i),
    .rst_n        (sysrst_n_i),
    .i_wr         (w_write),
    .i_wdata      (w_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_head_valid (w_head_valid),
    .o_next_avail (w_next_avail),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (fifo_count_o)
  );

  always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
    if (!sysrst_n_i) begin
      r_state      <= IDLE;
      r_tready     <= 1'b0;
      r_ts         <= '0;
      r_evnum      <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
      r_pend_drop  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_tready     <= 1'b1;
      r_ts         <= w_ts + 48'd1;
      r_evnum      <= w_evnum + {31'b0, w_write};
      r_drop_count <= (w_drop && w_drop_base != 16'hFFFF) ? w_drop_base + 16'd1 : w_drop_base;
      r_overflow   <= w_ovf_base | w_drop;
      if (w_write)     r_pend_drop <= 1'b0;
      else if (w_drop) r_pend_drop <= 1'b1;
    end
  end

  always_comb begin
    w_beat0               = {MAGIC, 48'h0};
    w_beat0[DROPFLAG_BIT] = w_head.dropflag;
    w_beat0[31:0]         = w_head.evnum;
  end

  always_comb begin
    w_state_next = r_state;
    m_ev_tvalid  = 1'b0;
    m_ev_tdata   = '0;
    m_ev_tlast   = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: if (w_head_valid && !w_empty) w_state_next = B0;
      B0: begin
        m_ev_tvalid = 1'b1;
        m_ev_tdata  = w_beat0;
        if (m_ev_tready) w_state_next = B1;
      end
      B1: begin
        m_ev_tvalid = 1'b1;
        m_ev_tdata  = w_head.data;
        if (m_ev_tready) w_state_next = B2;
      end
      B2: begin
        m_ev_tvalid = 1'b1;
        m_ev_tdata  = {16'h0, w_head.ts};
        m_ev_tlast  = 1'b1;
        if (m_ev_tready) begin
          w_pop        = 1'b1;
          w_state_next = w_next_avail ? B0 : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_pueo_evhdr_framer.sv
// tb/tb_pueo_evhdr_framer.sv - scoreboard bench for pueo_evhdr_framer
module tb_pueo_evhdr_framer;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          runrst = 1'b0;
  logic [63:0]   s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [63:0]   m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic [15:0]   drop_cnt;
  logic          ovf;
  logic [CW-1:0] fcnt;

  always #5 clk = ~clk;

  pueo_evhdr_framer #(.DEPTH(DEPTH), .MAGIC(16'hE5E1)) dut (
    .sysclk_i     (clk),
    .sysrst_n_i   (rst_n),
    .runrst_i     (runrst),
    .s_hdr_tdata  (s_tdata),
    .s_hdr_tvalid (s_tvalid),
    .s_hdr_tready (s_tready),
    .m_ev_tdata   (m_tdata),
    .m_ev_tvalid  (m_tvalid),
    .m_ev_tready  (m_tready),
    .m_ev_tlast   (m_tlast),
    .drop_count_o (drop_cnt),
    .overflow_o   (ovf),
    .fifo_count_o (fcnt)
  );

  typedef struct {
    logic [63:0] data;
    logic [31:0] evnum;
    logic [47:0] ts;
    logic        df;
  } frame_t;

  frame_t      sb[$];
  frame_t      cur;
  int          n_vec = 0;
  int          n_err = 0;
  longint      cyc = 0;
  longint      rr_cyc = 0;
  logic [31:0] m_ev = '0;
  logic        m_pend = 1'b0;
  int          m_drops = 0;
  bit          rnd_rdy = 1'b0;
  int          bidx = 0;
  logic        stalled = 1'b0;
  logic [63:0] held_d = '0;
  logic        held_l = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [63:0] d, input bit store, input bit rr);
    longint e;
    frame_t f;
    e = cyc + 1;
    s_tdata = d; s_tvalid = 1'b1; runrst = rr;
    if (rr) begin rr_cyc = e; m_ev = '0; m_drops = 0; end
    if (store) begin
      f.data = d; f.evnum = m_ev; f.ts = 48'(e - rr_cyc); f.df = m_pend;
      sb.push_back(f);
      m_ev = m_ev + 32'd1;
      m_pend = 1'b0;
    end else begin
      m_pend = 1'b1;
      m_drops++;
    end
    tick();
    s_tvalid = 1'b0; runrst = 1'b0;
  endtask

  task automatic run_reset_pulse();
    runrst = 1'b1;
    rr_cyc = cyc + 1; m_ev = '0; m_drops = 0;
    tick();
    runrst = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((sb.size() != 0 || m_tvalid || fcnt != '0) && k < 3000) begin
      tick(); k++;
    end
    chk({tag, "_fifo"}, 64'(fcnt), 64'd0);
    chk({tag, "_sb"}, 64'(sb.size()), 64'd0);
  endtask

  // Output monitor: pops the scoreboard at the first beat of each frame.
  always @(negedge clk) begin
    if (!rst_n) begin
      bidx = 0; stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 64'(m_tvalid), 64'd1);
        chk("stall_data", m_tdata, held_d);
        chk("stall_last", 64'(m_tlast), 64'(held_l));
      end
      if (m_tvalid && m_tready) begin
        if (bidx == 0) begin
          if (sb.size() == 0) chk("sb_has_frame", 64'(sb.size()), 64'd1);
          else cur = sb.pop_front();
        end
        case (bidx)
          0: begin
            chk("beat0", m_tdata, {16'hE5E1, 15'h0, cur.df, cur.evnum});
            chk("tlast0", 64'(m_tlast), 64'd0);
          end
          1: begin
            chk("beat1", m_tdata, cur.data);
            chk("tlast1", 64'(m_tlast), 64'd0);
          end
          default: begin
            chk("beat2", m_tdata, {16'h0, cur.ts});
            chk("tlast2", 64'(m_tlast), 64'd1);
          end
        endcase
        bidx = (bidx == 2) ? 0 : bidx + 1;
      end
      stalled = m_tvalid && !m_tready;
      held_d  = m_tdata;
      held_l  = m_tlast;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // reset state
    tick(); tick();
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata", m_tdata, 64'd0);
    chk("rst_tready", 64'(s_tready), 64'd0);
    chk("rst_fcnt", 64'(fcnt), 64'd0);
    rst_n = 1'b1; rr_cyc = cyc + 1;
    tick();
    chk("rel_tready", 64'(s_tready), 64'd1);

    // 1: single record, latency and content
    run_reset_pulse();
    tick(); tick(); tick();
    send(64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0);
    chk("t1_lat_n", 64'(m_tvalid), 64'd0);
    tick();
    chk("t1_lat_n1", 64'(m_tvalid), 64'd0);
    tick();
    chk("t1_lat_n2", 64'(m_tvalid), 64'd1);
    chk("t1_beat0", m_tdata, 64'hE5E1_0000_0000_0000);
    drain("t1");

    // 2: three back-to-back records, nine gapless beats
    run_reset_pulse();
    for (int i = 0; i < 3; i++) send({$urandom, $urandom}, 1'b1, 1'b0);
    k = 0;
    while (!m_tvalid && k < 20) begin tick(); k++; end
    for (int i = 0; i < 9; i++) begin
      chk("t2_nogap", 64'(m_tvalid), 64'd1);
      tick();
    end
    chk("t2_end_idle", 64'(m_tvalid), 64'd0);
    drain("t2");

    // 3: overflow with downstream stalled
    run_reset_pulse();
    m_tready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) send({$urandom, $urandom}, i < DEPTH, 1'b0);
    chk("t3_fcnt", 64'(fcnt), 64'(DEPTH));
    chk("t3_drops", 64'(drop_cnt), 64'(m_drops));
    chk("t3_ovf", 64'(ovf), 64'd1);
    chk("t3_tready", 64'(s_tready), 64'd1);
    m_tready = 1'b1;
    drain("t3");
    send(64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
    drain("t3b");

    // 4: random downstream back-pressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      send({$urandom, $urandom}, 1'b1, 1'b0);
      repeat (11) tick();
    end
    drain("t4");
    rnd_rdy = 1'b0; m_tready = 1'b1;

    // 5: runrst coincident with a record while two frames are queued
    run_reset_pulse();
    chk("t5_drop_clr", 64'(drop_cnt), 64'd0);
    chk("t5_ovf_clr", 64'(ovf), 64'd0);
    for (int i = 0; i < 5; i++) send({$urandom, $urandom}, 1'b1, 1'b0);
    drain("t5a");
    m_tready = 1'b0;
    send(64'h5555_0000_0000_0005, 1'b1, 1'b0);
    send(64'h6666_0000_0000_0006, 1'b1, 1'b0);
    send(64'h0000_AAAA_0000_0000, 1'b1, 1'b1);
    send(64'h1111_BBBB_0000_0001, 1'b1, 1'b0);
    chk("t5_fcnt", 64'(fcnt), 64'd4);
    m_tready = 1'b1;
    drain("t5");

    // 6: system reset in the middle of a frame
    send(64'hCAFE_F00D_0000_0006, 1'b1, 1'b0);
    k = 0;
    while (!(bidx == 1 && m_tvalid) && k < 20) begin tick(); k++; end
    chk("t6_in_b1", 64'(bidx), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_tvalid", 64'(m_tvalid), 64'd0);
    chk("t6_tdata", m_tdata, 64'd0);
    chk("t6_tlast", 64'(m_tlast), 64'd0);
    chk("t6_drop", 64'(drop_cnt), 64'd0);
    chk("t6_ovf", 64'(ovf), 64'd0);
    chk("t6_fcnt", 64'(fcnt), 64'd0);
    chk("t6_tready", 64'(s_tready), 64'd0);
    sb.delete();
    m_ev = '0; m_pend = 1'b0; m_drops = 0;
    tick(); tick();
    rst_n = 1'b1; rr_cyc = cyc + 1;
    chk("t6_rel_tready0", 64'(s_tready), 64'd0);
    chk("t6_rel_fcnt", 64'(fcnt), 64'd0);
    tick();
    chk("t6_rel_tready1", 64'(s_tready), 64'd1);
    send(64'hBEEF_0000_0000_0000, 1'b1, 1'b0);
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
